fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-cycle MIPS core. Sits directly upstream of the main/ALU decoder: it owns the program counter, fetches the word at PC from instruction memory over a req/ack handshake, and holds it as `instr` so the decoder can see `op`/`funct`. When the core retires the instruction, it loads the next PC from the decoder's `pcsrc`/`jump` outcome. A stalled memory is bounded by a timeout that raises a sticky error.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TIMEOUT`, 16, maximum FETCH cycles without `imem_ack` before error; legal range is ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  fetch request, held high while in FETCH.
- `imem_addr`  out  32  equals `pc` whenever `imem_req` is high.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; sampled only in FETCH.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  latched instruction; `instr[31:26]` is op and `instr[5:0]` is funct for the decoder.
- `instr_valid`  out  1  high in HOLD; the core executes `instr` this cycle.
- `advance`  in  1  core retires `instr`; honoured only in HOLD.
- `pcsrc`  in  1  branch taken (from controller).
- `jump`  in  1  J/JAL taken (from controller).
- `signimm`  in  32  sign-extended immediate, used for the branch offset.
- `pc`  out  32  current PC.
- `pcplus4`  out  32  `pc + 4`, combinational; serves as the JAL link value.
- `fetch_err`  out  1  sticky error flag.

## Operation
- States: FETCH, HOLD, ERR. Reset puts the block in FETCH with `pc`=RESET_PC, `instr`=0, timeout counter 0 and `fetch_err`=0.
- While `reset` is high, all outputs read as their reset values: `imem_req`=0, `instr_valid`=0, `pc`=RESET_PC.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`: latch `instr` ← `imem_rdata`, clear the counter, go to HOLD.
  - Otherwise the counter increments. When it reaches TIMEOUT (that is, TIMEOUT cycles with no ack), go to ERR.
- **HOLD:**
  - `instr_valid`=1 and `imem_req`=0; `instr` and `pc` are stable.
  - On `advance`: `pc` ← next PC, go to FETCH.
- **ERR:**
  - `fetch_err`=1, `imem_req`=0, `instr_valid`=0.
  - `pc` is frozen at the faulting address. Exit only via reset.
- Next-PC priority, evaluated only at `advance`:
  - `jump`: {`pcplus4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `pcsrc`: `pcplus4` + (`signimm` << 2).
  - else `pcplus4`.
- Arithmetic is modulo 2^32. PC wrap from 32'hFFFF_FFFC to 0 is legal and raises no error.
- Inputs ignored outside HOLD: `advance`, `pcsrc`, `jump`.
- `imem_ack` is ignored outside FETCH, including an ack that arrives in ERR or HOLD.

## Timing
- An ack in the same cycle as the first FETCH cycle is legal (combinational memory). Minimum latency is FETCH 1 cycle + HOLD 1 cycle, giving 2 cycles per instruction.
- `instr` and `instr_valid` update on the edge after the ack.
- The new `pc` and `imem_req`=1 appear on the edge after `advance`.
- Timeout: with no ack, ERR is entered on the TIMEOUT-th FETCH edge. An ack arriving in the TIMEOUT-th FETCH cycle itself wins: the block goes to HOLD, not ERR.
- Reset asserted mid-FETCH or mid-HOLD aborts the fetch; the next cycle is FETCH at RESET_PC.
- `pcplus4` is combinational from `pc`. All other outputs are registered or pure functions of state.

## Configuration
- `FETCH_JR_EN` defined: adds input ports `jr` (1) and `jr_target` (32).
  - `jr` has the highest next-PC priority, above `jump` and `pcsrc`.
  - If `jr_target[1:0]` ≠ 0 at `advance`, go to ERR with `pc` unchanged and `fetch_err`=1.
- `FETCH_JR_EN` undefined: the ports do not exist and the next-PC mux has three sources only.

## Test plan
- Reset, then memory acks in the same cycle: `pc`=0 and `imem_req`=1 → next cycle `instr_valid`=1 with `instr`=`imem_rdata`. Pulse `advance` with `pcsrc`=`jump`=0 → `pc`=4 and `imem_req`=1 one cycle later.
- In HOLD at `pc`=32'h0000_0040, `pcsrc`=1, `signimm`=32'hFFFF_FFFE, pulse `advance` → `pc`=32'h0000_003C. Repeat with both `jump`=1 and `pcsrc`=1 and `instr[25:0]`=26'h0000010 → `pc`=32'h0000_0040 (jump wins).
- TIMEOUT=16, no ack: `fetch_err` rises on the 16th FETCH edge, `imem_req` drops, `pc` holds. An `imem_ack` afterwards has no effect; `reset` clears everything. Separately, an ack in the 16th cycle → HOLD and `fetch_err`=0.
- `pc`=32'hFFFF_FFFC, `advance` with no branch → `pc`=0 and `fetch_err`=0.
- `reset` pulsed while in HOLD with `advance`=1 → next cycle FETCH at RESET_PC and `instr_valid`=0. Also verify `advance` pulsed during FETCH is ignored (`pc` unchanged).
- With `FETCH_JR_EN`: `jr`=1, `jr_target`=32'h0000_0100 → `pc`=32'h100. With `jr_target`=32'h0000_0102 → ERR, `pc` unchanged.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake, holds
// the word for decode, and flags a sticky error on memory timeout. Define FETCH_JR_EN for JR support.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
`ifdef FETCH_JR_EN
  input  logic        jr,
  input  logic [31:0] jr_target,
`endif
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        fetch_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic [31:0]   next_pc;
  logic          jr_bad;

  // Outputs are gated by reset so they read as reset values before the first edge.
  assign pc          = reset ? RESET_PC : pc_q;
  assign imem_addr   = pc;
  assign instr       = reset ? '0 : instr_q;
  assign pcplus4     = pc + 32'd4;
  assign imem_req    = (state == FETCH) && !reset;
  assign instr_valid = (state == HOLD)  && !reset;
  assign fetch_err   = (state == ERR)   && !reset;

  always_comb begin
    next_pc = pcplus4;
    jr_bad  = 1'b0;
    if (jump)
      next_pc = {pcplus4[31:28], instr_q[25:0], 2'b00};
    else if (pcsrc)
      next_pc = pcplus4 + (signimm << 2);
`ifdef FETCH_JR_EN
    if (jr) begin
      next_pc = jr_target;
      jr_bad  = |jr_target[1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            cnt     <= '0;
            state   <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(TIMEOUT - 1))
              state <= ERR;
          end
        end
        HOLD: begin
          if (advance) begin
            if (jr_bad) begin
              state <= ERR;
            end else begin
              pc_q  <= next_pc;
              state <= FETCH;
            end
          end
        end
        ERR:     state <= ERR;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of fetch/advance records with a
// scoreboard queue for fetched words, plus hand sequences for timeout and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        advance;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        fetch_err;
`ifdef FETCH_JR_EN
  logic        jr;
  logic [31:0] jr_target;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .advance(advance), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
`ifdef FETCH_JR_EN
    .jr(jr), .jr_target(jr_target),
`endif
    .pc(pc), .pcplus4(pcplus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned lat;
    logic [31:0] rdata;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] pc_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_word(input logic [31:0] d);
    imem_ack   = 1'b1;
    imem_rdata = d;
    exp_q.push_back(d);
    step();
    imem_ack   = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int unsigned k = 0;
    logic [31:0] e;
    while (!instr_valid && k < 4) begin
      step();
      k++;
    end
    if (!instr_valid) begin
      check1({name, "_valid_timeout"}, instr_valid, 1'b1);
    end else begin
      check({name, "_latency"}, k, 32'd0);
      if (exp_q.size() == 0) begin
        check({name, "_sb_underflow"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check(name, instr, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 32'h2008_0005, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
    tbl[1] = '{2, 32'h1000_000E, 1'b1, 1'b0, 32'h0000_000E, 32'h0000_0040};
    tbl[2] = '{1, 32'h1000_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_003C};
    tbl[3] = '{0, 32'h0800_0010, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0040};
    tbl[4] = '{1, 32'h0BFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 32'h0FFF_FFFC};
    tbl[5] = '{3, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0000, 32'h1000_0000};
    tbl[6] = '{0, 32'h0800_0001, 1'b0, 1'b1, 32'h0000_0000, 32'h1000_0004};
    tbl[7] = '{2, 32'h1000_FFFD, 1'b1, 1'b0, 32'h3BFF_FFFD, 32'hFFFF_FFFC};
    tbl[8] = '{0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[9] = '{1, 32'h1000_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    advance = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = '0;
`ifdef FETCH_JR_EN
    jr = 1'b0; jr_target = '0;
`endif
    #1;
    check1("rst_req_pre", imem_req, 1'b0);
    check("rst_pc_pre", pc, 32'h0);
    step();
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_err", fetch_err, 1'b0);
    check("rst_instr", instr, 32'h0);
    step();
    reset = 1'b0;
    #1;
    check1("post_rst_req", imem_req, 1'b1);
    check("post_rst_pc", pc, 32'h0);
    check("pcplus4", pcplus4, 32'h4);

    // advance/jump during FETCH must not move the PC
    advance = 1'b1; jump = 1'b1; pcsrc = 1'b1; signimm = 32'h10;
    step();
    step();
    advance = 1'b0; jump = 1'b0; pcsrc = 1'b0; signimm = '0;
    check("fetch_adv_pc", pc, 32'h0);
    check1("fetch_adv_req", imem_req, 1'b1);
    check1("fetch_adv_valid", instr_valid, 1'b0);

    pc_model = 32'h0;
    for (int i = 0; i < 10; i++) begin
      check1("fetch_req", imem_req, 1'b1);
      check("fetch_addr", imem_addr, pc_model);
      repeat (tbl[i].lat) step();
      ack_word(tbl[i].rdata);
      wait_valid("vec_instr");
      check1("hold_req", imem_req, 1'b0);
      pcsrc = tbl[i].pcsrc; jump = tbl[i].jump; signimm = tbl[i].signimm;
      advance = 1'b1;
      step();
      advance = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = '0;
      check("next_pc", pc, tbl[i].exp_pc);
      check1("refetch_req", imem_req, 1'b1);
      check1("vec_err", fetch_err, 1'b0);
      pc_model = tbl[i].exp_pc;
    end

    // timeout: 15 silent cycles are fine, the 16th edge enters ERR
    repeat (15) step();
    check1("to15_err", fetch_err, 1'b0);
    check1("to15_req", imem_req, 1'b1);
    step();
    check1("to16_err", fetch_err, 1'b1);
    check1("to16_req", imem_req, 1'b0);
    check1("to16_valid", instr_valid, 1'b0);
    check("to16_pc", pc, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check1("err_ack_err", fetch_err, 1'b1);
    check("err_ack_instr", instr, 32'h1000_FFFF);
    advance = 1'b1;
    step();
    advance = 1'b0;
    check("err_adv_pc", pc, 32'h0);
    check1("err_adv_valid", instr_valid, 1'b0);
    reset = 1'b1;
    #1;
    check1("err_rst_req", imem_req, 1'b0);
    step();
    check1("err_rst_err", fetch_err, 1'b0);
    check("err_rst_instr", instr, 32'h0);
    reset = 1'b0;
    #1;
    check1("err_rst_req_after", imem_req, 1'b1);

    // ack in the 16th cycle wins over the timeout
    repeat (15) step();
    ack_word(32'h2402_0007);
    wait_valid("late_ack_instr");
    check1("late_ack_err", fetch_err, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ack = 1'b0;
    check("hold_ack_instr", instr, 32'h2402_0007);
    check1("hold_ack_valid", instr_valid, 1'b1);
    advance = 1'b1;
    step();
    advance = 1'b0;
    check("late_next_pc", pc, 32'h4);
    ack_word(32'h0800_0100);
    wait_valid("pre_rst_instr");
    reset = 1'b1; advance = 1'b1; jump = 1'b1;
    step();
    reset = 1'b0; advance = 1'b0; jump = 1'b0;
    #1;
    check("hold_rst_pc", pc, 32'h0);
    check1("hold_rst_valid", instr_valid, 1'b0);
    check1("hold_rst_req", imem_req, 1'b1);
    check("hold_rst_instr", instr, 32'h0);

`ifdef FETCH_JR_EN
    ack_word(32'h0320_0008);
    wait_valid("jr_instr");
    jr = 1'b1; jr_target = 32'h0000_0100; advance = 1'b1;
    step();
    advance = 1'b0; jr = 1'b0;
    check("jr_pc", pc, 32'h0000_0100);
    ack_word(32'h0320_0008);
    wait_valid("jr_bad_instr");
    jr = 1'b1; jr_target = 32'h0000_0102; advance = 1'b1;
    step();
    advance = 1'b0; jr = 1'b0;
    check1("jr_bad_err", fetch_err, 1'b1);
    check("jr_bad_pc", pc, 32'h0000_0100);
    check1("jr_bad_req", imem_req, 1'b0);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
